// File: rtl/my_buffer_reader.sv
// Streams committed buffer words to an AXI-style master port.
// Two-cycle buffer reads are credit-limited so the 4-entry FIFO never overflows.
module my_buffer_reader #(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [AW-1:0] commit_ptr,
  output logic [AW-1:0] dpra,
  input  logic [DW-1:0] qdpo,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [AW-1:0] rd_ptr,
  output logic          busy
);

  logic [AW-1:0] issue_q, issue_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          v1_q, v2_q;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] fifo_q [4];
  logic [DW-1:0] fifo_d [4];
  logic [2:0]    credit;
  logic [2:0]    wr_idx;
  logic          issue, push, pop;

  assign dpra     = issue_q;
  assign rd_ptr   = rd_q;
  assign m_tdata  = fifo_q[0];
  assign m_tvalid = (cnt_q != 3'd0);
  assign busy     = (rd_q != commit_ptr);

  always_comb begin
    credit  = cnt_q + {2'b0, v1_q} + {2'b0, v2_q};
    issue   = en && (issue_q != commit_ptr)
              && (credit < 3'd4);
    push    = v2_q;
    pop     = m_tvalid && m_tready;
    issue_d = issue ? issue_q + AW'(1) : issue_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + {2'b0, push} - {2'b0, pop};
    wr_idx  = cnt_q - {2'b0, pop};
    fifo_d  = fifo_q;
    if (pop) begin
      for (int i = 0; i < 3; i++) begin
        fifo_d[i] = fifo_q[i+1];
      end
    end
    // Head slot 0 drives the stream; new words land behind survivors.
    for (int i = 0; i < 4; i++) begin
      if (push && (wr_idx == 3'(i))) begin
        fifo_d[i] = qdpo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_q <= '0;
      rd_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      issue_q <= issue_d;
      rd_q    <= rd_d;
      v1_q    <= issue;
      v2_q    <= v1_q;
      cnt_q   <= cnt_d;
      fifo_q  <= fifo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push && !pop) begin
      assert (cnt_q < 3'd4)
        else $error("my_buffer_reader: fifo overflow");
    end
  end

endmodule

// File: doc/my_buffer_reader.md
MY_BUFFER_READER -- requirements
Module: my_buffer_reader

Interface
REQ-001 SHALL have parameters: AW, default 10, buffer address width in words; DW, default 64, data width.
REQ-002 SHALL have ports, one per line, as follows:
- clk  input  1  single clock for all logic; also drives the buffer read port.
- reset_n  input  1  synchronous active-low reset.
- en  input  1  read-issue enable.
- commit_ptr  input  AW  write-side pointer: address one past the last committed word.
- dpra  output  AW  buffer read address.
- qdpo  input  DW  buffer read data.
- m_tdata  output  DW  stream data.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- rd_ptr  output  AW  address of the oldest word not yet accepted downstream, returned to the writer as its free-space limit.
- busy  output  1  asserted when rd_ptr != commit_ptr.

Function
REQ-003 SHALL treat buffer read latency as exactly 2 cycles: an address driven on dpra in cycle t yields its word on qdpo during cycle t+2.
REQ-004 SHALL hold an internal issue_ptr (AW bits) and drive dpra = issue_ptr continuously from a register.
REQ-005 SHALL issue a read in cycle t iff all of the following hold: en=1, issue_ptr != commit_ptr, and (fifo_cnt + inflight) < 4.
REQ-006 On issue, SHALL increment issue_ptr by 1, modulo 2^AW, with wrap from 2^AW-1 to 0.
REQ-007 SHALL track in-flight reads with a 2-stage valid shift pipeline and write qdpo into a 4-entry output FIFO at the end of cycle t+2 for each read issued in cycle t.
REQ-008 The credit rule in REQ-005 SHALL guarantee the FIFO never overflows; an overflow is a design error and SHALL be flagged by a simulation assertion.
REQ-009 m_tdata/m_tvalid SHALL be driven from the FIFO head register, so the first word appears in cycle t+3.
- Zero-wait pattern: commit_ptr advance in cycle c, m_tvalid=1 in cycle c+3.
REQ-010 Handshake: a word transfers when m_tvalid and m_tready are both 1.
- While m_tvalid=1 and m_tready=0, m_tdata SHALL hold stable.
- m_tvalid SHALL NOT deassert without a transfer.
REQ-011 With m_tready held at 1 and sufficient committed words, SHALL sustain one word per cycle, with no bubbles after the first word.
REQ-012 On each transfer, rd_ptr SHALL increment by 1 modulo 2^AW.
REQ-013 Invariant: rd_ptr <= issue_ptr <= commit_ptr in modular order, and issue_ptr - rd_ptr <= 4.
REQ-014 Words SHALL be delivered in strict address order, with no duplicates and no skips.
REQ-015 en=0 SHALL stop new issues only; in-flight reads complete and the FIFO continues draining.
REQ-016 Simultaneous FIFO push and pop in the same cycle SHALL be supported at any count from 0 to 4, including push on empty (word visible next cycle) and pop on full.
REQ-017 commit_ptr is trusted to advance monotonically (modulo) and never pass rd_ptr.
- A commit_ptr == issue_ptr condition means empty; there is no full-buffer ambiguity on the read side.

Reset
REQ-018 While reset_n=0 at a clk edge, SHALL clear the following to 0: issue_ptr, rd_ptr, fifo_cnt, pipeline valids, m_tvalid, m_tdata, dpra. busy SHALL follow REQ-002 combinationally.
REQ-019 Reset asserted mid-operation SHALL discard in-flight reads and FIFO contents; no pre-reset word SHALL appear on the stream after reset_n returns to 1.

Verification
REQ-020 Reset idle: reset_n=0 for 2 cycles, commit_ptr=0 -> m_tvalid=0, dpra=0, rd_ptr=0, busy=0.
REQ-021 Streaming: preload addresses 0..3 with 0xA0..0xA3, m_tready=1, commit_ptr 0->4 in cycle c.
- Expected: m_tvalid=1 in cycles c+3..c+6 with data A0, A1, A2, A3.
- Expected after the last transfer: rd_ptr=4, busy=0.
REQ-022 Backpressure: preload 0..7, m_tready=0, commit_ptr=8.
- Expected while m_tready=0: issue_ptr stops at 4 and m_tdata holds A0.
- Then m_tready=1 -> words A0..A7 in order, no gaps after the first, rd_ptr=8.
REQ-023 Wrap (AW=4): advance rd_ptr to 14, preload 14, 15, 0, 1, set commit_ptr=2.
- Expected: those 4 words delivered in order, then rd_ptr=2 and issue_ptr=2.
REQ-024 Mid-op reset: 2 reads in flight and 2 words in the FIFO, assert reset_n=0 for 1 cycle.
- Expected: m_tvalid=0 and rd_ptr=0 the next cycle, and no stale word is emitted afterwards.
REQ-025 Enable gating: en=0 with commit_ptr=6 after 2 words issued.
- Expected: those 2 words are delivered, then no further issue; raising en resumes from address 2.
